// File: rtl/fetch_unit_pkg.sv
// Shared instruction-set definitions for the Sudoku-solver CPU.
// Opcode encodings and instruction field positions, used by fetch and decode.
package fetch_unit_pkg;

    // Instruction field positions.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int TGT_MSB = 11;
    localparam int TGT_LSB = 4;

    localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
    localparam int TGT_W = TGT_MSB - TGT_LSB + 1;

    // Opcode encodings.
    typedef enum logic [OPC_W-1:0] {
        OPC_NOP = 4'h0,
        OPC_LI  = 4'h1,
        OPC_ADD = 4'h2,
        OPC_SUB = 4'h3,
        OPC_LD  = 4'h4,
        OPC_ST  = 4'h5,
        OPC_CMP = 4'h6,
        OPC_JNZ = 4'hE,
        OPC_JMP = 4'hF
    } opcode_t;

    // Opcode field of an instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [15:0] op);
        return op[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_predecode.sv
// Combinational predecode of the instruction currently returned by imem:
// spots unconditional jumps and jumps that target their own address.
module fetch_unit_predecode
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int OP_W = 16
) (
    input  logic [OP_W-1:0] op,
    input  logic [PC_W-1:0] pc,
    output logic            is_jmp,
    output logic            self_jmp,
    output logic [PC_W-1:0] target
);

    // Low bits carry no information for jump detection.
    logic unused_low_bits;

    // Decode jump type and target from the raw instruction.
    always_comb begin
        is_jmp          = (opcode_of(op[15:0]) == OPC_JMP);
        target          = PC_W'(op[TGT_MSB:TGT_LSB]);
        self_jmp        = is_jmp && (target == pc);
        unused_low_bits = ^op[TGT_LSB-1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures imem output into the IR,
// resolves JMP locally, halts on a self-jump and accepts execute redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              OP_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = 8'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] pc_o,
    input  logic [OP_W-1:0] op_i,
    output logic [OP_W-1:0] ir_o,
    output logic [PC_W-1:0] ir_pc_o,
    output logic            ir_valid_o,
    input  logic            ir_ready_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            halt_o,
    output logic [15:0]     fetch_cnt_o
);

    logic            is_jmp;
    logic            self_jmp;
    logic [PC_W-1:0] target;

    logic            transfer;
    logic            load;

    logic [PC_W-1:0] pc_next;
    logic [OP_W-1:0] ir_next;
    logic [PC_W-1:0] ir_pc_next;
    logic            ir_valid_next;
    logic            halt_next;
    logic [15:0]     fetch_cnt_next;
    logic [15:0]     fetch_cnt_inc;

    fetch_unit_predecode #(
        .PC_W (PC_W),
        .OP_W (OP_W)
    ) u_predecode (
        .op       (op_i),
        .pc       (pc_o),
        .is_jmp   (is_jmp),
        .self_jmp (self_jmp),
        .target   (target)
    );

    // Next-state selection: redirect beats jump, jump beats a normal load.
    always_comb begin
        pc_next        = pc_o;
        ir_next        = ir_o;
        ir_pc_next     = ir_pc_o;
        ir_valid_next  = ir_valid_o;
        halt_next      = halt_o;
        fetch_cnt_next = fetch_cnt_o;

        // A redirect squashes the IR, so no transfer happens in that cycle.
        transfer      = ir_valid_o && ir_ready_i && !redirect_i;
        load          = !halt_o && (!ir_valid_o || transfer);
        fetch_cnt_inc = (fetch_cnt_o == 16'hFFFF) ? fetch_cnt_o : fetch_cnt_o + 16'd1;

        if (redirect_i) begin
            pc_next       = redirect_pc_i;
            ir_valid_next = 1'b0;
            halt_next     = 1'b0;
        end else if (load && is_jmp) begin
            ir_valid_next  = 1'b0;
            fetch_cnt_next = fetch_cnt_inc;
            if (self_jmp) begin
                halt_next = 1'b1;
            end else begin
                pc_next = target;
            end
        end else if (load) begin
            ir_next        = op_i;
            ir_pc_next     = pc_o;
            ir_valid_next  = 1'b1;
            pc_next        = pc_o + PC_W'(1);
            fetch_cnt_next = fetch_cnt_inc;
        end else if (transfer) begin
            // Halted: decode drained the last entry and nothing refills it.
            ir_valid_next = 1'b0;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_o        <= RESET_PC;
            ir_o        <= '0;
            ir_pc_o     <= '0;
            ir_valid_o  <= 1'b0;
            halt_o      <= 1'b0;
            fetch_cnt_o <= '0;
        end else begin
            pc_o        <= pc_next;
            ir_o        <= ir_next;
            ir_pc_o     <= ir_pc_next;
            ir_valid_o  <= ir_valid_next;
            halt_o      <= halt_next;
            fetch_cnt_o <= fetch_cnt_next;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit Sudoku-solver CPU. It sits directly upstream of `imem`: it owns the program counter, drives `pc` into `imem`, and captures the returned `op` into an instruction register (IR). It hands IR to decode through a valid/ready handshake. Unconditional `JMP` is resolved here, a self-jump halts fetch, and the conditional `JNZ` is predicted not-taken, with execute supplying a redirect.

## Interface
- `RESET_PC`, default 8'd0: PC value after reset.
- `PC_W`, default 8: PC width (matches `imem` address).
- `OP_W`, default 16: instruction width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pc_o` out PC_W: fetch address to `imem`.
- `op_i` in OP_W: instruction from `imem`; combinational, valid in the same cycle as `pc_o`.
- `ir_o` out OP_W: registered instruction to decode.
- `ir_pc_o` out PC_W: address `ir_o` was fetched from.
- `ir_valid_o` out 1: IR holds a live instruction.
- `ir_ready_i` in 1: decode accepts IR this cycle.
- `redirect_i` in 1: execute resolved a taken `JNZ`.
- `redirect_pc_i` in PC_W: redirect target.
- `halt_o` out 1: fetch stopped on a self-jump.
- `fetch_cnt_o` out 16: count of instructions fetched; saturates at 16'hFFFF.

## Operation
- Opcode field is `op[15:12]`. Branch target field is `op[11:4]`.
- Predecode flags come from `op_i`: `is_jmp` (opcode == JMP) and `self_jmp` (`is_jmp` and target == `pc_o`).
- A decode transfer happens when `ir_valid_o && ir_ready_i && !redirect_i`.
- `load` = `!halt_o && (!ir_valid_o || transfer)`.

Per-cycle priority:
1. **`redirect_i`**
   - `pc_o` <= `redirect_pc_i`.
   - `ir_valid_o` <= 0 (flush). This applies even if `ir_ready_i` = 1; the IR entry is wrong-path.
   - `halt_o` <= 0.
   - `op_i` is discarded and not counted.
2. **`load` with `is_jmp`**
   - `pc_o` <= target.
   - IR is not written; `ir_valid_o` <= 0.
   - `fetch_cnt_o` increments.
   - If `self_jmp`, `halt_o` <= 1 and `pc_o` holds.
3. **`load` otherwise**
   - `ir_o` <= `op_i`, `ir_pc_o` <= `pc_o`, `ir_valid_o` <= 1.
   - `pc_o` <= `pc_o` + 1.
   - `fetch_cnt_o` increments.
4. **Else (stall or halted)**
   - All state holds.
   - A transfer without a load (halted) clears `ir_valid_o`.

Boundary conditions:
- PC arithmetic is modulo 2^PC_W: 8'd255 + 1 = 8'd0, with no flag.
- `JNZ` is passed through to decode like any ALU op, predicted not-taken.
- `halt_o` is released only by `redirect_i` or reset. A wrong-path self-jump must be recoverable.
- `fetch_cnt_o` never wraps.
- Reset mid-operation clears everything immediately (asynchronous). The first fetch happens on the first rising edge after deassertion.

## Timing
Reset values:
- `pc_o` = RESET_PC
- `ir_o` = 0
- `ir_pc_o` = 0
- `ir_valid_o` = 0
- `halt_o` = 0
- `fetch_cnt_o` = 0

Latencies:
- **Fetch:** an address on `pc_o` in cycle N appears on `ir_o` in cycle N+1.
- **JMP:** costs one bubble, since IR is invalid for one cycle.
- **Redirect:** asserted in cycle N; `pc_o` = target in N+1; target instruction on `ir_o` in N+2.

Handshake rules:
- Sustained throughput is one instruction per cycle with `ir_ready_i` = 1.
- `ir_o` and `ir_pc_o` are stable while `ir_valid_o && !ir_ready_i`.

## Structure
- Opcode constants (JMP, JNZ, …) come from the shared `def.h`; this block adds no encodings.
- Field positions (`OPC_MSB`=15, `OPC_LSB`=12, `TGT_MSB`=11, `TGT_LSB`=4) go into `def.h` alongside the opcodes, so decode reuses them.
- One combinational sub-module, `fetch_predecode`: input `op`, `pc`; output `is_jmp`, `self_jmp`, `target`.
- PC, IR, halt and counter registers live in `fetch_unit`.

## Test plan
- **Reset:** hold `rst_n`=0 mid-run, then release.
  - All outputs are at reset values asynchronously.
  - With ready=1, `ir_pc_o` shows 0 and 1 on the first two edges.
- **Straight line plus JMP:** `imem` {0: LI, 1: LI, 2: JMP 12}, ready=1.
  - `ir_pc_o` sequence 0, 1, bubble (`ir_valid_o`=0), 12.
  - `fetch_cnt_o`=4 after 12 is loaded.
- **Backpressure:** hold ready=0 for 3 cycles with IR holding pc 13.
  - `ir_o`/`ir_pc_o` and `pc_o`=14 are frozen.
  - Releasing ready gives 14 next.
- **Redirect:** IR holds a `JNZ` at 167; execute asserts `redirect_i` with 151 while ready=1.
  - The IR entry fetched from 168 is flushed.
  - `pc_o`=151 next cycle; `ir_pc_o`=151 two cycles after the redirect.
- **Halt and release:** fetch `JMP 169` at 169.
  - `halt_o`=1, `pc_o` stays 169, counter frozen.
  - A later redirect to 12 clears halt and fetches 12.
- **Wrap and saturation:** a NOP run from 254 gives `ir_pc_o` 254, 255, 0.
  - With `fetch_cnt_o` forced near max, it stays at FFFF.
